sr_shift_unit: RTL and testbench

//  Multicycle right shifter: logical (SRL) and arithmetic (SRA) right shift, plus optional rotate-right.

---
 rtl/sr_shift_unit.sv | 127 ++++++++++++
 tb/tb_sr_shift_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sr_shift_unit.sv
// Multicycle right shifter (SRL/SRA, optional ROR): one log-shifter stage per clock, MSB stage first.
// Optional feature macro: ROTATE_EN (op=10 rotates right; without it op=10 acts as SRL).
module sr_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);
    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [1:0] OP_SRA = 2'b01;
`ifdef ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b10;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic [SHAMT_W:0]   amt;
    logic [WIDTH-1:0]   stage_val;
`ifdef ROTATE_EN
    logic [SHAMT_W:0]   rot_sh;
`endif

    // One stage: shift by 2**k when the matching shamt bit is set, else pass through.
    always_comb begin
        amt       = {{SHAMT_W{1'b0}}, 1'b1} << k_q;
        stage_val = work_q;
`ifdef ROTATE_EN
        rot_sh    = (SHAMT_W+1)'(WIDTH) - amt;
`endif
        if (shamt_q[k_q]) begin
            if (op_q == OP_SRA)
                stage_val = (work_q >> amt) | ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> amt));
`ifdef ROTATE_EN
            else if (op_q == OP_ROR)
                stage_val = (work_q >> amt) | (work_q << rot_sh);
`endif
            else
                stage_val = work_q >> amt;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        k_d      = k_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            SHIFT: begin
                work_d   = stage_val;
                result_d = stage_val;
                if (k_q == '0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new start (DONE allows back-to-back issue).
                busy_d = 1'b0;
                if (ctrl_start) begin
                    state_d = SHIFT;
                    work_d  = data_operand;
                    shamt_d = shamt;
                    op_d    = op;
                    sign_d  = data_operand[WIDTH-1];
                    k_d     = K_W'(SHAMT_W-1);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            k_q      <= K_W'(SHAMT_W-1);
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            k_q      <= k_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_sr_shift_unit.sv
// Self-checking bench for sr_shift_unit: directed cases, random ops vs. an arithmetic model, handshake corners.
module tb_sr_shift_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_operand = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  op = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    sr_shift_unit dut (
        .clock(clock), .reset(reset), .ctrl_start(ctrl_start),
        .data_operand(data_operand), .shamt(shamt), .op(op),
        .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic [1:0] o);
        case (o)
            2'b01: return $signed(a) >>> s;
`ifdef ROTATE_EN
            2'b10: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
`endif
            default: return a >> s;
        endcase
    endfunction

    // Drive a start sampled by the next edge; returns at #1 after that edge with inputs scrambled.
    task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
        ctrl_start = 1'b1; data_operand = a; shamt = s; op = o;
        @(posedge clock); #1;
        ctrl_start = 1'b0; data_operand = $urandom; shamt = 5'($urandom); op = 2'($urandom);
    endtask

    // Waits (bounded) for the ready pulse; lat = edges since the start edge, 0 on timeout.
    task automatic wait_rdy(output int lat, output logic [31:0] res);
        lat = 0; res = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin lat = c; res = data_result; break; end
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
        int lat; logic [31:0] res, exp;
        exp = model(a, int'(s), o);
        issue(a, s, o);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL %s busy after start: got %b want 1", name, busy);
        end
        wait_rdy(lat, res);
        tests_run++;
        if (lat !== 5 || res !== exp) begin
            tests_failed++;
            $display("FAIL %s: a=%h sh=%0d op=%0d got %h lat %0d want %h lat 5", name, a, s, o, res, lat, exp);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL %s busy in ready cycle: got %b want 0", name, busy);
        end
        @(posedge clock); #1;
        tests_run++;
        if (data_resultRDY !== 1'b0 || data_result !== exp) begin
            tests_failed++;
            $display("FAIL %s after pulse: rdy %b res %h want rdy 0 res %h", name, data_resultRDY, data_result, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: res %h rdy %b busy %b want 0 0 0", data_result, data_resultRDY, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_one("sra_neg_4", 32'h8000_0000, 5'd4, 2'b01);
        run_one("srl_msb_4", 32'h8000_0000, 5'd4, 2'b00);
        run_one("sra_31", 32'h8000_0001, 5'd31, 2'b01);
        run_one("srl_0", 32'h7FFF_FFFF, 5'd0, 2'b00);
        run_one("ror_1", 32'h0000_0001, 5'd1, 2'b10);
        run_one("op11_4", 32'h0000_0010, 5'd4, 2'b11);
        run_one("sra_pos_31", 32'h7FFF_FFFF, 5'd31, 2'b01);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_one("random", $urandom, 5'($urandom), 2'($urandom));
    endtask

    task automatic test_ignore_busy();
        int lat; logic [31:0] res, exp;
        exp = model(32'hF000_00F0, 8, 2'b01);
        issue(32'hF000_00F0, 5'd8, 2'b01);
        @(posedge clock); #1;
        issue(32'h1234_5678, 5'd3, 2'b00);
        wait_rdy(lat, res);
        // First start edge was two edges before the ignored one.
        tests_run++;
        if (lat !== 3 || res !== exp) begin
            tests_failed++;
            $display("FAIL ignore_busy: got %h lat %0d want %h lat 3", res, lat, exp);
        end
        @(posedge clock); #1;
        tests_run++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            tests_failed++; $display("FAIL ignore_busy idle: busy %b rdy %b want 0 0", busy, data_resultRDY);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res, exp_a, exp_b;
        exp_a = model(32'hDEAD_BEEF, 12, 2'b00);
        exp_b = model(32'h9000_0000, 7, 2'b01);
        issue(32'hDEAD_BEEF, 5'd12, 2'b00);
        wait_rdy(lat, res);
        tests_run++;
        if (lat !== 5 || res !== exp_a) begin
            tests_failed++; $display("FAIL b2b first: got %h lat %0d want %h lat 5", res, lat, exp_a);
        end
        issue(32'h9000_0000, 5'd7, 2'b01);
        wait_rdy(lat, res);
        tests_run++;
        if (lat !== 5 || res !== exp_b) begin
            tests_failed++; $display("FAIL b2b second: got %h lat %0d want %h lat 5", res, lat, exp_b);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_abort_reset();
        int lat; logic [31:0] res;
        issue(32'hFFFF_0000, 5'd5, 2'b00);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || data_result !== 32'h0 || data_resultRDY !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: busy %b res %h rdy %b want 0 0 0", busy, data_result, data_resultRDY);
        end
        wait_rdy(lat, res);
        tests_run++;
        if (lat !== 0) begin
            tests_failed++; $display("FAIL abort no_pulse: got ready at %0d want none", lat);
        end
        run_one("after_abort", 32'hC000_0003, 5'd2, 2'b01);
    endtask

    initial begin
        test_reset();
        @(posedge clock); #1;
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
